// File: rtl/regfile_pkg.sv
// Shared types, default geometry and the byte-merge helper for the multi-port register file.
package regfile_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_e;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_DEPTH  = 32;
   localparam int ADDR_W     = $clog2(DEF_DEPTH);
   localparam int BE_W       = DEF_DATA_W / 8;

   // Widest word merge_be handles; callers zero-extend and truncate around it.
   localparam int MAX_DATA_W = 256;
   localparam int MAX_BE_W   = MAX_DATA_W / 8;

   function automatic logic [MAX_DATA_W-1:0] merge_be(
      input logic [MAX_DATA_W-1:0] old_v,
      input logic [MAX_DATA_W-1:0] new_v,
      input logic [MAX_BE_W-1:0]   be
   );
      logic [MAX_DATA_W-1:0] res;
      for (int b = 0; b < MAX_BE_W; b++) begin
         res[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: zeroes one entry per cycle, then hands the file over to RUN.
module regfile_clear_seq
   import regfile_pkg::*;
#(
   parameter  int DEPTH = 32,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   output logic             busy_o,
   output logic             clr_we_o,
   output logic [PTR_W-1:0] clr_addr_o
);

   state_e           state_q, state_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;

   // NOTE: reset is synchronous and active-low, so it only takes effect on a clock edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= CLEAR;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // NOTE: every signal gets a default before the case so no latch can be inferred.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      busy_o   = 1'b0;
      clr_we_o = 1'b0;
      case (state_q)
         CLEAR: begin
            busy_o   = 1'b1;
            clr_we_o = 1'b1;
            ptr_d    = ptr_q + 1'b1;
            if (ptr_q == PTR_W'(DEPTH - 1)) begin
               state_d = RUN;
            end
         end
         RUN: begin
            state_d = RUN;
         end
      endcase
   end

   assign clr_addr_o = ptr_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file: byte-enabled writes, registered reads with optional
// same-cycle write bypass, and a post-reset clear sweep so the storage can map to RAM.
module regfile_mp
   import regfile_pkg::DEF_DATA_W, regfile_pkg::DEF_DEPTH,
          regfile_pkg::MAX_DATA_W, regfile_pkg::MAX_BE_W, regfile_pkg::merge_be;
#(
   parameter  int DATA_W   = DEF_DATA_W,
   parameter  int DEPTH    = DEF_DEPTH,
   parameter  int NUM_RD   = 3,
   parameter  int ZERO_REG = 1,
   parameter  int BYPASS   = 1,
   localparam int ADDR_W   = $clog2(DEPTH),
   localparam int BE_W     = DATA_W / 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD-1:0]        rd_en,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_valid,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic [BE_W-1:0]          wr_be,
   output logic                     busy
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic              user_we;

   regfile_clear_seq #(.DEPTH(DEPTH)) u_clear_seq (
      .clk        (clk),
      .rst        (rst),
      .busy_o     (busy),
      .clr_we_o   (clr_we),
      .clr_addr_o (clr_addr)
   );

   // Qualified write: dropped while sweeping or in reset, with no byte enables, or to hardwired r0.
   assign user_we = rst && !busy && wr_en && (wr_be != '0)
                    && !((ZERO_REG != 0) && (wr_addr == '0));

   // NOTE: the storage array has no reset; the clear sweep zeroes it so it can map onto RAM.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem_q[clr_addr] <= '0;
      end else if (user_we) begin
         for (int b = 0; b < BE_W; b++) begin
            if (wr_be[b]) begin
               mem_q[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
         end
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic              hit;
      logic              take;
      logic [DATA_W-1:0] data_d, data_q;
      logic              valid_q;

      assign addr = rd_addr[p*ADDR_W +: ADDR_W];
      assign hit  = (BYPASS != 0) && user_we && (wr_addr == addr);
      assign take = rd_en[p] && !busy;

      always_comb begin
         data_d = mem_q[addr];
         if (hit) begin
            data_d = DATA_W'(merge_be(MAX_DATA_W'(mem_q[addr]), MAX_DATA_W'(wr_data),
                                      MAX_BE_W'(wr_be)));
         end
         if ((ZERO_REG != 0) && (addr == '0)) begin
            data_d = '0;
         end
      end

      always_ff @(posedge clk) begin
         if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
         end else begin
            valid_q <= take;
            if (take) begin
               data_q <= data_d;
            end
         end
      end

      assign rd_valid[p]                 = valid_q;
      assign rd_data[p*DATA_W +: DATA_W] = data_q;
   end

endmodule
